// File: rtl/fp16_dot_sequencer_if.sv
// fp16_dot_sequencer_if: operand stream, MAC operand/clear/accumulator and result port of the sequencer
interface fp16_dot_sequencer_if #(parameter int bw = 16, parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [bw-1:0]    in_a;
  logic [bw-1:0]    in_b;
  logic             in_last;
  logic [bw-1:0]    mac_a;
  logic [bw-1:0]    mac_b;
  logic             mac_clr;
  logic [bw-1:0]    mac_acc;
  logic             out_valid;
  logic             out_ready;
  logic [bw-1:0]    out_data;
  logic [CNT_W-1:0] out_len;
  logic             busy;
  modport master (
    input  in_valid, in_a, in_b, in_last, mac_acc, out_ready,
    output in_ready, mac_a, mac_b, mac_clr, out_valid, out_data, out_len, busy
  );
  modport slave (
    output in_valid, in_a, in_b, in_last, mac_acc, out_ready,
    input  in_ready, mac_a, mac_b, mac_clr, out_valid, out_data, out_len, busy
  );
endinterface

// File: rtl/fp16_dot_sequencer.sv
// fp16_dot_sequencer: streams fp16 operand pairs into the MAC and returns the drained dot product
module fp16_dot_sequencer #(
  parameter int bw      = 16,
  parameter int MAC_LAT = 3,
  parameter int CNT_W   = 8
) (
  input logic CLK,
  input logic RESETn,
  fp16_dot_sequencer_if.master bus
);
  localparam int DW = $clog2(MAC_LAT + 2);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUT} state_t;
  state_t           state;
  logic [bw-1:0]    a_q, b_q, data_q;
  logic [CNT_W-1:0] cnt, len_q;
  logic [DW-1:0]    drain;
  logic             rdy_q, clr_q, vld_q, busy_q;
  logic             xfer;
  assign xfer          = bus.in_valid & rdy_q;
  assign bus.in_ready  = rdy_q;
  assign bus.mac_a     = a_q;
  assign bus.mac_b     = b_q;
  assign bus.mac_clr   = clr_q;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_len   = len_q;
  assign bus.busy      = busy_q;
  // Idle cycles feed zero operands so the accumulator only ever adds +0
  always_ff @(posedge CLK or negedge RESETn)
    if (!RESETn) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      cnt    <= '0;
      len_q  <= '0;
      drain  <= '0;
      rdy_q  <= 1'b0;
      clr_q  <= 1'b0;
      vld_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (bus.in_valid) begin
            state  <= CLEAR;
            clr_q  <= 1'b1;
            busy_q <= 1'b1;
          end
        CLEAR: begin
          clr_q <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          cnt   <= '0;
          rdy_q <= 1'b1;
          state <= FEED;
        end
        FEED: begin
          a_q <= xfer ? bus.in_a : '0;
          b_q <= xfer ? bus.in_b : '0;
          if (xfer) cnt <= &cnt ? cnt : cnt + 1'b1;
          if (xfer && bus.in_last) begin
            rdy_q <= 1'b0;
            drain <= DW'(MAC_LAT);
            state <= DRAIN;
          end
        end
        DRAIN: begin
          a_q <= '0;
          b_q <= '0;
          if (drain == '0) begin
            data_q <= bus.mac_acc;
            len_q  <= cnt;
            vld_q  <= 1'b1;
            state  <= OUT;
          end else drain <= drain - 1'b1;
        end
        OUT:
          if (bus.out_ready) begin
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
